bus2st_pkt_packer: RTL
======================

// Module: bus2st_pkt_packer
// PURPOSE
//   Single-clock, parametrised bus-to-stream packetiser for the turbo datapath.
//   Accepts wide BUS words over a valid/ready handshake and unpacks each word LSB-first into ST-bit soft symbols.
//   Emits them as one framed packet (sop/eop) of runtime length cfg_pkt_len.
//   Sits between the memory-read bus and the turbo decoder sink in the clk_st domain.
//   Supersedes the fixed-length 1028-symbol packer with:
//   - runtime packet length
//   - discard of residual symbols in the last word
//   - length-error detection
//   - a packet counter
// PARAMETERS
//   BUS            512   bus word width, bits
//   ST             12    stream symbol width, bits
//   NUM_ST_PER_BUS 42    symbols used per bus word; NUM_ST_PER_BUS*ST <= BUS, upper bits ignored
//   LEN_W          13    width of cfg_pkt_len
//   MAX_PKT_LEN    6148  largest legal packet length, symbols (6144+4 tail)
//   CNT_W          16    width of pkt_cnt
// PORTS
//   clk          in   1               clock
//   rst_n        in   1               asynchronous reset, active low
//   cfg_pkt_len  in   LEN_W           packet length in symbols, sampled at first word of packet
//   bus_data     in   BUS             bus word; symbol k = bus_data[k*ST +: ST]
//   bus_en       in   1               bus word valid
//   bus_ready    out  1               packer can accept a bus word this cycle
//   st_data      out  ST              stream symbol
//   st_valid     out  1               st_data valid
//   st_sop       out  1               first symbol of packet
//   st_eop       out  1               last symbol of packet
//   st_ready     in   1               downstream accepts symbol
//   len_err      out  1               sticky: illegal cfg_pkt_len seen
//   pkt_done     out  1               one-cycle pulse when eop symbol is accepted
//   pkt_cnt      out  CNT_W           packets completed, wraps modulo 2^CNT_W
// BEHAVIOUR
//   Reset (async assert, sync deassert by caller):
//   - state=IDLE, bus_ready=1, st_valid/sop/eop=0, st_data=0, len_err=0, pkt_done=0, pkt_cnt=0.
//   - Reset mid-packet abandons the packet; no eop, no pkt_done.
//   Handshakes:
//   - Word accepted when bus_en && bus_ready; bus_en while bus_ready=0 is ignored (word is not captured).
//   - Symbol transferred when st_valid && st_ready.
//   - st_valid, once high, holds with stable data/sop/eop until accepted.
//   Timing:
//   - All outputs are driven from registers only; no combinational input-to-output path.
//   - Latency: word accepted at cycle t -> its first symbol valid at t+1.
//   - One bus word buffered; bus_ready=1 only in IDLE and WAIT.
//   Registers:
//   - buf: BUS-bit word buffer.
//   - sym_idx: 0..NUM_ST_PER_BUS-1, position within the word.
//   - pkt_idx: 0..len-1, position within the packet.
//   - len: latched cfg_pkt_len.
//   IDLE:
//   - On accept with 1 <= cfg_pkt_len <= MAX_PKT_LEN: latch len and buf, sym_idx=0, pkt_idx=0 -> EMIT, sop armed.
//   - On accept with cfg_pkt_len==0 or >MAX_PKT_LEN: drop word, set len_err, stay IDLE.
//   EMIT:
//   - Outputs: st_valid=1, st_data=buf[sym_idx*ST +: ST], st_sop=(pkt_idx==0), st_eop=(pkt_idx==len-1).
//   - On transfer with eop: pulse pkt_done next cycle, pkt_cnt+1 -> IDLE; residual symbols of buf are discarded.
//   - Else on transfer with sym_idx==NUM_ST_PER_BUS-1: pkt_idx+1 -> WAIT.
//   - Else on transfer: sym_idx+1, pkt_idx+1.
//   - With st_ready=0: hold all state.
//   WAIT:
//   - bus_ready=1, st_valid=0.
//   - On accept: buf=bus_data, sym_idx=0 -> EMIT; cfg_pkt_len is not resampled.
//   - Eop and word exhaustion coincide (len multiple of NUM_ST_PER_BUS): eop wins -> IDLE, not WAIT.
//   Packet framing:
//   - Words per packet = ceil(len/NUM_ST_PER_BUS); the next packet always starts at a new word.
//   - len==1 gives st_sop=st_eop=1 on the same symbol.
//   - cfg_pkt_len changes mid-packet have no effect.
//   - pkt_cnt wraps from 2^CNT_W-1 to 0.
// TESTING
//   Length 1028, st_ready=1, 25 words sent back-to-back:
//   - exactly 1028 transfers; sop on symbol 0 of word 0; eop on word 24 symbol 19.
//   - symbols 20..41 of word 24 are never output; pkt_cnt=1.
//   Same run with st_ready toggled by a random 50% pattern:
//   - identical symbol sequence; st_data stable while st_valid && !st_ready.
//   - bus_ready low in EMIT; bus_en pulses during EMIT are ignored.
//   Length 42, then length 84:
//   - eop on sym 41 of word 0 -> IDLE; next packet sop from a fresh word; eop on word 1 sym 41.
//   Length 1: sop=eop=1 on symbol 0; pkt_done pulses; bus_ready=1 on the next cycle.
//   Length 0, then length 6149: each word dropped; len_err=1 and stays set; no st_valid; pkt_cnt=0.
//   Reset mid-packet, asserted at symbol 500 of a 1028 packet:
//   - all outputs return to reset values immediately.
//   - a new 1028 packet then frames correctly from sop.
//   pkt_cnt forced near wrap (CNT_W=4 build): 17 packets -> pkt_cnt=1.

Source files
------------

// File: rtl/bus2st_pkt_packer.sv
// Bus-to-stream packetiser: unpacks buffered bus words LSB-first into ST-bit
// symbols and frames them as one sop/eop packet of runtime length cfg_pkt_len.
module bus2st_pkt_packer #(
  parameter int BUS            = 512,
  parameter int ST             = 12,
  parameter int NUM_ST_PER_BUS = 42,
  parameter int LEN_W          = 13,
  parameter int MAX_PKT_LEN    = 6148,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [LEN_W-1:0] cfg_pkt_len,
  input  logic [BUS-1:0]   bus_data,
  input  logic             bus_en,
  output logic             bus_ready,
  output logic [ST-1:0]    st_data,
  output logic             st_valid,
  output logic             st_sop,
  output logic             st_eop,
  input  logic             st_ready,
  output logic             len_err,
  output logic             pkt_done,
  output logic [CNT_W-1:0] pkt_cnt
);

  localparam int USED      = NUM_ST_PER_BUS * ST;
  localparam int SIDX_W    = (NUM_ST_PER_BUS > 1) ? $clog2(NUM_ST_PER_BUS) : 1;
  localparam int SYM_SLOTS = 1 << SIDX_W;
  localparam logic [SIDX_W-1:0] LAST_SYM = SIDX_W'(NUM_ST_PER_BUS - 1);
  localparam logic [LEN_W-1:0]  MAX_LEN  = LEN_W'(MAX_PKT_LEN);

  typedef enum logic [1:0] {IDLE, EMIT, WAIT} state_t;

  state_t                         state, state_nxt;
  logic [USED-1:0]                word_buf;
  logic [SIDX_W-1:0]              sym_idx;
  logic [LEN_W-1:0]               pkt_idx;
  logic [LEN_W-1:0]               len;
  logic [SYM_SLOTS-1:0][ST-1:0]   syms;

  logic accept, xfer, cfg_ok, last_sym;
  logic load, err_set;

  // Symbol view of the buffered word; slots past NUM_ST_PER_BUS read as zero
  // so the sym_idx mux never indexes outside the array.
  genvar g;
  generate
    for (g = 0; g < SYM_SLOTS; g++) begin : g_sym
      if (g < NUM_ST_PER_BUS) begin : g_used
        assign syms[g] = word_buf[g*ST +: ST];
      end else begin : g_pad
        assign syms[g] = '0;
      end
    end
    if (USED < BUS) begin : g_unused
      logic unused_hi;
      assign unused_hi = ^bus_data[BUS-1:USED];
    end
  endgenerate

  // Every output is a decode of flop state only.
  assign st_valid  = (state == EMIT);
  assign bus_ready = (state == IDLE) || (state == WAIT);
  assign st_data   = st_valid ? syms[sym_idx] : '0;
  assign st_sop    = st_valid && (pkt_idx == '0);
  assign st_eop    = st_valid && (pkt_idx == len - LEN_W'(1));

  assign accept   = bus_en && bus_ready;
  assign xfer     = st_valid && st_ready;
  assign cfg_ok   = (cfg_pkt_len != '0) && (cfg_pkt_len <= MAX_LEN);
  assign last_sym = (sym_idx == LAST_SYM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    err_set   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (cfg_ok) begin
            load      = 1'b1;
            state_nxt = EMIT;
          end else begin
            err_set   = 1'b1;
          end
        end
      end
      EMIT: begin
        // eop beats word exhaustion so the next packet starts on a fresh word
        if (xfer) begin
          if (st_eop)        state_nxt = IDLE;
          else if (last_sym) state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (accept) begin
          load      = 1'b1;
          state_nxt = EMIT;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_buf <= '0;
      sym_idx  <= '0;
      pkt_idx  <= '0;
      len      <= '0;
    end else if (load) begin
      word_buf <= bus_data[USED-1:0];
      sym_idx  <= '0;
      // length and packet position are only taken at the first word
      if (state == IDLE) begin
        len     <= cfg_pkt_len;
        pkt_idx <= '0;
      end
    end else if (xfer && !st_eop) begin
      pkt_idx <= pkt_idx + LEN_W'(1);
      if (!last_sym) sym_idx <= sym_idx + SIDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_err  <= 1'b0;
      pkt_done <= 1'b0;
      pkt_cnt  <= '0;
    end else begin
      len_err  <= len_err | err_set;
      pkt_done <= xfer && st_eop;
      if (xfer && st_eop) pkt_cnt <= pkt_cnt + CNT_W'(1);
    end
  end

endmodule
